matrix_scanner: RTL and testbench

Display-side consumer of the 192-bit playfield matrix (12 rows × 16 columns) produced by the game logic. It captures a frame into a shadow buffer at frame boundaries and row-multiplexes it onto an LED dot-matrix as a one-hot row strobe plus 16 registered column bits. A valid/ack handshake ensures a frame is never torn mid-scan.

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/dwell_counter.sv | 27 ++
 rtl/matrix_scanner.sv | 94 +++++++++
 tb/tb_matrix_scanner.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared playfield-matrix geometry, scanner state encoding and row extraction
// helper for the LED matrix scanner.
package matrix_pkg;

    localparam int MATRIX_ROWS = 12;
    localparam int MATRIX_COLS = 16;
    localparam int MATRIX_BITS = MATRIX_ROWS * MATRIX_COLS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

    // Row 0 is the top row and sits in the most significant slice.
    function automatic logic [MATRIX_COLS-1:0] row_bits(input logic [MATRIX_BITS-1:0] data,
                                                        input logic [3:0] r);
        return data[(MATRIX_ROWS - 1 - int'(r)) * MATRIX_COLS +: MATRIX_COLS];
    endfunction

endpackage

// File: rtl/dwell_counter.sv
// Terminal-count counter with synchronous clear and enable; wraps to zero
// on the terminal-count cycle so back-to-back periods need no extra clear.
module dwell_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] limit,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    assign tc = en && (count == limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/matrix_scanner.sv
// Row-multiplexed LED matrix scanner with tear-free frame capture.
// Optional inter-row blanking is enabled by defining MATRIX_SCAN_BLANK_EN.
module matrix_scanner
    import matrix_pkg::*;
#(
    parameter int ROW_DWELL    = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [191:0] frame_data,
    input  logic         frame_valid,
    output logic         frame_ack,
    output logic [11:0]  row_sel,
    output logic [15:0]  col_data,
    output logic         frame_done
);

    localparam int CW_D = $clog2(ROW_DWELL);
    localparam int CW_B = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam int CW = (CW_B > CW_D) ? CW_B : CW_D;
`else
    localparam int CW = CW_D;
`endif
    localparam logic [CW-1:0] SHOW_LIM  = CW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES - 1);

    scan_state_e      state_q;
    logic [3:0]       row_q;
    logic [191:0]     shadow_q;
    logic             tc;
    logic             advance, go_blank, last_row, light, capture;
    logic [3:0]       light_row;
    logic [191:0]     src;

    // One counter times both the lit dwell and the dark gap.
    dwell_counter #(.WIDTH(CW)) u_dwell (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state_q == ST_IDLE),
        .en    (state_q != ST_IDLE),
        .limit ((state_q == ST_BLANK) ? BLANK_LIM : SHOW_LIM),
        .tc    (tc)
    );

    always_comb begin
`ifdef MATRIX_SCAN_BLANK_EN
        go_blank = (state_q == ST_SHOW) && tc;
        advance  = (state_q == ST_BLANK) && tc;
`else
        go_blank = 1'b0;
        advance  = (state_q == ST_SHOW) && tc;
`endif
        last_row  = (row_q == 4'(MATRIX_ROWS - 1));
        light     = ((state_q == ST_IDLE) && frame_valid) || advance;
        // frame_valid is only honoured in IDLE or on the frame-boundary edge.
        capture   = frame_valid && ((state_q == ST_IDLE) || (advance && last_row));
        light_row = ((state_q == ST_IDLE) || last_row) ? 4'd0 : row_q + 4'd1;
        src       = capture ? frame_data : shadow_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            shadow_q   <= '0;
            row_sel    <= '0;
            col_data   <= '0;
            frame_ack  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_ack  <= 1'b0;
            frame_done <= 1'b0;
            if (capture) begin
                shadow_q  <= frame_data;
                frame_ack <= 1'b1;
            end
            if (go_blank) begin
                state_q  <= ST_BLANK;
                row_sel  <= '0;
                col_data <= '0;
            end else if (light) begin
                // Strobe and columns always update together from one source.
                state_q    <= ST_SHOW;
                row_q      <= light_row;
                row_sel    <= 12'(1) << light_row;
                col_data   <= row_bits(src, light_row);
                frame_done <= advance && last_row;
            end
        end
    end

endmodule

// File: tb/tb_matrix_scanner.sv
// Self-checking bench for matrix_scanner: timeline reference model feeding a
// per-cycle scoreboard, a spot-check table, and hand-written corner sequences.
module tb_matrix_scanner;

    localparam int D = 4;
    localparam int BC = 2;
`ifdef MATRIX_SCAN_BLANK_EN
    localparam int B = BC;
`else
    localparam int B = 0;
`endif
    localparam int SLOT   = D + B;
    localparam int PERIOD = 12 * SLOT;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [191:0] frame_data = '0;
    logic         frame_valid = 1'b0;
    logic         frame_ack;
    logic [11:0]  row_sel;
    logic [15:0]  col_data;
    logic         frame_done;

    matrix_scanner #(.ROW_DWELL(D), .BLANK_CYCLES(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ack   (frame_ack),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] rs;
        logic [15:0] col;
        logic        ack;
        logic        done;
    } outs_t;

    typedef struct {
        int          at;
        logic        v;
        logic [11:0] rs;
        logic [15:0] col;
        logic        ack;
        logic        done;
    } vec_t;

    outs_t        sb[$];
    vec_t         tbl[$];
    int           vectors = 0;
    int           miscompares = 0;
    int           cyc = 0;

    bit           m_have = 0;
    int           m_p = 0;
    logic [191:0] m_shadow = '0;
    logic         m_ack = 0;
    logic         m_done = 0;

    logic [191:0] fa, fb, fc;

    function automatic logic [15:0] rva(int r);
        if (r == 0)  return 16'hA5A5;
        if (r == 11) return 16'h000F;
        return {4'(r), 4'hC, 4'(r), 4'h3};
    endfunction

    function automatic logic [15:0] rvb(int r);
        return {4'hB, 4'h0, 4'(r), 4'(11 - r)};
    endfunction

    function automatic logic [191:0] build(int which);
        logic [191:0] d = '0;
        for (int r = 0; r < 12; r++)
            d[(11 - r) * 16 +: 16] = (which == 0) ? rva(r) : (which == 1) ? rvb(r) : 16'h5A00 ^ 16'(r);
        return d;
    endfunction

    // Expected outputs from the position inside the frame timeline.
    function automatic outs_t model_out();
        outs_t o = '0;
        int slot, w;
        if (m_have) begin
            slot = m_p / SLOT;
            w    = m_p % SLOT;
            if (w < D) begin
                o.rs  = 12'(1) << slot;
                o.col = m_shadow[(11 - slot) * 16 +: 16];
            end
            o.ack  = m_ack;
            o.done = m_done;
        end
        return o;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic v, input logic [191:0] d);
        outs_t e, a;
        frame_valid = v;
        frame_data  = d;
        @(posedge clk);
        if (!rst_n) begin
            m_have = 0; m_p = 0; m_shadow = '0; m_ack = 0; m_done = 0;
        end else begin
            m_ack = 0; m_done = 0;
            if (!m_have) begin
                if (v) begin m_have = 1; m_p = 0; m_shadow = d; m_ack = 1; end
            end else begin
                m_p++;
                if (m_p == PERIOD) begin
                    m_p = 0; m_done = 1;
                    if (v) begin m_shadow = d; m_ack = 1; end
                end
            end
        end
        sb.push_back(model_out());
        @(negedge clk);
        e = sb.pop_front();
        a = '{rs: row_sel, col: col_data, ack: frame_ack, done: frame_done};
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL scoreboard cyc %0d: got rs=%h col=%h ack=%b done=%b expected rs=%h col=%h ack=%b done=%b",
                     cyc, a.rs, a.col, a.ack, a.done, e.rs, e.col, e.ack, e.done);
        end
        cyc++;
    endtask

    initial begin
        int f0;
        fa = build(0);
        fb = build(1);
        fc = build(2);

`ifdef MATRIX_SCAN_BLANK_EN
        tbl.push_back('{0,   0, 12'h001, 16'hA5A5, 1, 0});
        tbl.push_back('{1,   0, 12'h001, 16'hA5A5, 0, 0});
        tbl.push_back('{3,   0, 12'h001, 16'hA5A5, 0, 0});
        tbl.push_back('{4,   0, 12'h000, 16'h0000, 0, 0});
        tbl.push_back('{5,   0, 12'h000, 16'h0000, 0, 0});
        tbl.push_back('{6,   0, 12'h002, 16'h1C13, 0, 0});
        tbl.push_back('{66,  0, 12'h800, 16'h000F, 0, 0});
        tbl.push_back('{70,  0, 12'h000, 16'h0000, 0, 0});
        tbl.push_back('{71,  0, 12'h000, 16'h0000, 0, 0});
        tbl.push_back('{72,  0, 12'h001, 16'hA5A5, 0, 1});
        tbl.push_back('{144, 0, 12'h001, 16'hA5A5, 0, 1});
`else
        tbl.push_back('{0,   0, 12'h001, 16'hA5A5, 1, 0});
        tbl.push_back('{1,   0, 12'h001, 16'hA5A5, 0, 0});
        tbl.push_back('{3,   0, 12'h001, 16'hA5A5, 0, 0});
        tbl.push_back('{4,   0, 12'h002, 16'h1C13, 0, 0});
        tbl.push_back('{44,  0, 12'h800, 16'h000F, 0, 0});
        tbl.push_back('{47,  0, 12'h800, 16'h000F, 0, 0});
        tbl.push_back('{48,  0, 12'h001, 16'hA5A5, 0, 1});
        tbl.push_back('{49,  0, 12'h001, 16'hA5A5, 0, 0});
        tbl.push_back('{96,  0, 12'h001, 16'hA5A5, 0, 1});
`endif

        // Reset, then idle with frame_valid low: everything stays dark.
        repeat (3) tick(0, fa);
        rst_n = 1'b1;
        repeat (20) tick(0, fa);
        chk("idle_row_sel", 32'(row_sel), 32'h0);
        chk("idle_col", 32'(col_data), 32'h0);

        // Capture frame A and walk the spot-check table.
        tick(1, fa);
        cyc = 0;
        foreach (tbl[i]) begin
            while (cyc < tbl[i].at) tick(tbl[i].v, fa);
            chk($sformatf("tbl%0d_row_sel", tbl[i].at), 32'(row_sel), 32'(tbl[i].rs));
            chk($sformatf("tbl%0d_col", tbl[i].at), 32'(col_data), 32'(tbl[i].col));
            chk($sformatf("tbl%0d_ack", tbl[i].at), 32'(frame_ack), 32'(tbl[i].ack));
            chk($sformatf("tbl%0d_done", tbl[i].at), 32'(frame_done), 32'(tbl[i].done));
        end

        // Mid-frame: C offered then withdrawn, B offered from cycle 10 on.
        f0 = cyc;
        while (cyc < f0 + PERIOD) begin
            if (cyc >= f0 + 3 && cyc < f0 + 6)  tick(1, fc);
            else if (cyc >= f0 + 10)            tick(1, fb);
            else                                tick(0, fa);
        end
        chk("swap_ack", 32'(frame_ack), 32'h1);
        chk("swap_done", 32'(frame_done), 32'h1);
        chk("swap_row_sel", 32'(row_sel), 32'h001);
        chk("swap_col", 32'(col_data), 32'hB00B);

        // Reset in the middle of row 6 of frame B.
        repeat (6 * SLOT + 1) tick(0, fb);
        chk("row6_row_sel", 32'(row_sel), 32'h040);
        chk("row6_col", 32'(col_data), 32'hB065);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_row_sel", 32'(row_sel), 32'h0);
        chk("async_col", 32'(col_data), 32'h0);
        chk("async_ack_done", 32'({frame_ack, frame_done}), 32'h0);
        repeat (2) tick(0, fa);
        rst_n = 1'b1;
        repeat (3) tick(0, fa);
        tick(1, fa);
        chk("restart_row_sel", 32'(row_sel), 32'h001);
        chk("restart_col", 32'(col_data), 32'hA5A5);
        chk("restart_ack", 32'(frame_ack), 32'h1);
        repeat (PERIOD + 2) tick(0, fa);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
